// File: rtl/sfx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfx_pkg
// Description : Shared constants for the Pong sound-effect sequencer: note
//               frequencies (Hz), effect ids, effect lengths, FSM state type
//               and the constant note lookup used by the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sfx_pkg;

    // Note frequencies in Hz
    localparam int NOTE_BB    = 466;
    localparam int NOTE_C     = 523;
    localparam int NOTE_D     = 587;
    localparam int NOTE_EB    = 622;
    localparam int NOTE_E     = 659;
    localparam int NOTE_B     = 987;
    // Default "no sound" value, above the audible range of the buzzer
    localparam int SILENCE_HZ = 20000;

    // Effect ids; a higher id has higher priority
    localparam logic [1:0] SFX_PADDLE = 2'd0;
    localparam logic [1:0] SFX_BORDER = 2'd1;
    localparam logic [1:0] SFX_WIN    = 2'd2;

    // Effect lengths in notes
    localparam logic [2:0] LEN_PADDLE = 3'd5;
    localparam logic [2:0] LEN_BORDER = 3'd2;
    localparam logic [2:0] LEN_WIN    = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } sfx_state_t;

    // Index of the last note of an effect
    function automatic logic [2:0] sfx_last(input logic [1:0] id);
        case (id)
            SFX_PADDLE: sfx_last = LEN_PADDLE - 3'd1;
            SFX_BORDER: sfx_last = LEN_BORDER - 3'd1;
            SFX_WIN:    sfx_last = LEN_WIN - 3'd1;
            default:    sfx_last = 3'd0;
        endcase
    endfunction

    // Note frequency of a given effect step; 15 bits covers SILENCE_HZ
    function automatic logic [14:0] sfx_note(input logic [1:0] id,
                                             input logic [2:0] step);
        sfx_note = 15'(SILENCE_HZ);
        case (id)
            SFX_PADDLE: begin
                case (step)
                    3'd0, 3'd1:       sfx_note = 15'(NOTE_BB);
                    3'd2, 3'd3, 3'd4: sfx_note = 15'(NOTE_D);
                    default:          sfx_note = 15'(SILENCE_HZ);
                endcase
            end
            SFX_BORDER: begin
                case (step)
                    3'd0:    sfx_note = 15'(NOTE_B);
                    3'd1:    sfx_note = 15'(NOTE_E);
                    default: sfx_note = 15'(SILENCE_HZ);
                endcase
            end
            SFX_WIN: begin
                case (step)
                    3'd0:    sfx_note = 15'(NOTE_BB);
                    3'd1:    sfx_note = 15'(NOTE_C);
                    3'd2:    sfx_note = 15'(NOTE_D);
                    3'd3:    sfx_note = 15'(NOTE_BB);
                    3'd4:    sfx_note = 15'(NOTE_D);
                    3'd5:    sfx_note = 15'(NOTE_EB);
                    default: sfx_note = 15'(SILENCE_HZ);
                endcase
            end
            default: sfx_note = 15'(SILENCE_HZ);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sfx_sequencer_if
// Description : Control/status bundle between game logic (master) and the
//               sound-effect sequencer (slave).
//               trig[2:0] effect requests, repeat_en, mute  (master -> slave)
//               tone, busy, sfx_id, step, done               (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface sfx_sequencer_if #(
    parameter int TONE_W = 32
);
    logic [2:0]        trig;
    logic              repeat_en;
    logic              mute;
    logic [TONE_W-1:0] tone;
    logic              busy;
    logic [1:0]        sfx_id;
    logic [2:0]        step;
    logic              done;

    modport master (
        output trig, repeat_en, mute,
        input  tone, busy, sfx_id, step, done
    );

    modport slave (
        input  trig, repeat_en, mute,
        output tone, busy, sfx_id, step, done
    );
endinterface
`default_nettype wire

// File: rtl/beat_timer.sv
`default_nettype none
// ============================================================================
// Module      : beat_timer
// Description : Free-running beat divider. Counts 0..DIV-1 and pulses tick
//               for the single cycle the count sits at DIV-1; clear forces
//               the count back to 0 on the next edge.
//               Ports: clk, rst (async, active high), clear -> tick
// Revision    : 1.0 - initial release
// ============================================================================
module beat_timer #(
    parameter int DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    output logic      tick
);
    localparam int              c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sfx_sequencer
// Description : Event-driven Pong sound-effect player. Rising edges on
//               trig start paddle/border/win effects with priority
//               preemption and retrigger; notes advance once per beat and
//               a registered tone (Hz) feeds the buzzer tone generator.
//               Ports: clk, rst (async, active high),
//                      bus (sfx_sequencer_if.slave): trig, repeat_en, mute
//                      in; tone, busy, sfx_id, step, done out
// Revision    : 1.0 - initial release
// ============================================================================
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BEAT_HZ = 8,
    parameter int TONE_W  = 32,
    parameter int SILENCE = SILENCE_HZ
) (
    input  wire logic      clk,
    input  wire logic      rst,
    sfx_sequencer_if.slave bus
);
    localparam int                c_DIV     = CLK_HZ / BEAT_HZ;
    localparam logic [TONE_W-1:0] c_SILENCE = TONE_W'(SILENCE);

    sfx_state_t        r_state;
    logic [2:0]        r_trig_q;
    logic [1:0]        r_id;
    logic [2:0]        r_step;
    logic              r_done;
    logic              r_busy;
    logic [TONE_W-1:0] r_tone;

    sfx_state_t        w_nxt_state;
    logic [1:0]        w_nxt_id;
    logic [2:0]        w_nxt_step;
    logic              w_nxt_done;
    logic              w_clear;
    logic              w_tick;
    logic [2:0]        w_event;
    logic              w_any;
    logic [1:0]        w_sel;
    logic [TONE_W-1:0] w_nxt_tone;

    beat_timer #(
        .DIV (c_DIV)
    ) u_beat_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // A held trigger level only fires once
    assign w_event = bus.trig & ~r_trig_q;
    assign w_any   = |w_event;
    assign w_sel   = w_event[2] ? SFX_WIN :
                     w_event[1] ? SFX_BORDER : SFX_PADDLE;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_id    = r_id;
        w_nxt_step  = r_step;
        w_nxt_done  = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Counter is held at 0 so the first note gets a full beat
                w_clear = 1'b1;
                if (w_any) begin
                    w_nxt_state = ST_PLAY;
                    w_nxt_id    = w_sel;
                    w_nxt_step  = 3'd0;
                end
            end
            ST_PLAY: begin
                // An accepted event wins over a beat boundary on the same edge,
                // which also suppresses the done pulse
                if (w_any && (w_sel >= r_id)) begin
                    w_nxt_id   = w_sel;
                    w_nxt_step = 3'd0;
                    w_clear    = 1'b1;
                end else if (w_tick) begin
                    if (r_step < sfx_last(r_id)) begin
                        w_nxt_step = r_step + 3'd1;
                    end else if (bus.repeat_en) begin
                        w_nxt_step = 3'd0;
                    end else begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_done  = 1'b1;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Tone follows the next state so it is valid on the edge the note starts
    assign w_nxt_tone = ((w_nxt_state == ST_PLAY) && !bus.mute) ?
                        TONE_W'(sfx_note(w_nxt_id, w_nxt_step)) : c_SILENCE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_trig_q <= 3'd0;
            r_id     <= 2'd0;
            r_step   <= 3'd0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_tone   <= c_SILENCE;
        end else begin
            r_state  <= w_nxt_state;
            r_trig_q <= bus.trig;
            r_id     <= w_nxt_id;
            r_step   <= w_nxt_step;
            r_done   <= w_nxt_done;
            r_busy   <= (w_nxt_state == ST_PLAY);
            r_tone   <= w_nxt_tone;
        end
    end

    assign bus.tone   = r_tone;
    assign bus.busy   = r_busy;
    assign bus.sfx_id = r_id;
    assign bus.step   = r_step;
    assign bus.done   = r_done;
endmodule
`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfx_sequencer
// Description : Self-checking bench for sfx_sequencer (DIV = 4). Per-cycle
//               vectors of inputs and expected outputs are built from the
//               effect note tables, driven, queued, and compared after
//               each clock edge; async reset is checked by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfx_sequencer;
    localparam int c_TONE_W = 32;
    localparam int c_SIL    = 20000;
    localparam int c_DIV    = 4;

    typedef struct {
        logic [2:0] trig;
        logic       rep;
        logic       mute;
        int         tone;
        logic       busy;
        logic [1:0] id;
        logic [2:0] step;
        logic       done;
    } vec_t;

    logic clk;
    logic rst;
    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec;
    int   n_bad;

    sfx_sequencer_if #(.TONE_W(c_TONE_W)) bus ();

    sfx_sequencer #(
        .CLK_HZ  (16),
        .BEAT_HZ (4),
        .TONE_W  (c_TONE_W),
        .SILENCE (c_SIL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int tb_note(input int id, input int s);
        int paddle[5];
        int border[2];
        int win[6];
        paddle = '{466, 466, 587, 587, 587};
        border = '{987, 659};
        win    = '{466, 523, 587, 466, 587, 622};
        case (id)
            0:       return paddle[s];
            1:       return border[s];
            default: return win[s];
        endcase
    endfunction

    task automatic add(input logic [2:0] t, input logic rep, input logic mute,
                       input int tone, input logic busy, input int id,
                       input int step, input logic done);
        vec_t v;
        v.trig = t;   v.rep  = rep; v.mute = mute; v.tone = tone;
        v.busy = busy; v.id  = 2'(id); v.step = 3'(step); v.done = done;
        vecs.push_back(v);
    endtask

    // One vector per cycle for steps s0..s1 of an effect. t is applied on
    // the first cycle (every cycle when hold=1); mute from cycle mute_from.
    task automatic notes(input logic [2:0] t, input bit hold, input int id,
                         input int s0, input int s1, input bit rep,
                         input int mute_from);
        int  k;
        bit  m;
        k = 0;
        for (int s = s0; s <= s1; s++) begin
            for (int c = 0; c < c_DIV; c++) begin
                m = (mute_from >= 0) && (k >= mute_from);
                add((k == 0 || hold) ? t : 3'd0, rep, m,
                    m ? c_SIL : tb_note(id, s), 1'b1, id, s, 1'b0);
                k++;
            end
        end
    endtask

    task automatic idle(input int n, input logic [2:0] t, input int id,
                        input int step, input bit first_done);
        for (int i = 0; i < n; i++)
            add(t, 1'b0, 1'b0, c_SIL, 1'b0, id, step, first_done && (i == 0));
    endtask

    task automatic check(input string name, input vec_t e);
        n_vec++;
        if (bus.tone !== c_TONE_W'(e.tone) || bus.busy !== e.busy ||
            bus.sfx_id !== e.id || bus.step !== e.step || bus.done !== e.done) begin
            n_bad++;
            $display("FAIL %s #%0d: got tone=%0d busy=%b id=%0d step=%0d done=%b, want tone=%0d busy=%b id=%0d step=%0d done=%b",
                     name, n_vec, bus.tone, bus.busy, bus.sfx_id, bus.step, bus.done,
                     e.tone, e.busy, e.id, e.step, e.done);
        end
    endtask

    // Drive each pending vector, queue its expectation, compare after the edge
    task automatic run(input string name);
        vec_t v;
        vec_t e;
        while (vecs.size() > 0) begin
            v = vecs.pop_front();
            bus.trig      = v.trig;
            bus.repeat_en = v.rep;
            bus.mute      = v.mute;
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(name, e);
        end
    endtask

    vec_t rv;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.trig = 3'd0;
        bus.repeat_en = 1'b0;
        bus.mute = 1'b0;
        rv.trig = 3'd0; rv.rep = 1'b0; rv.mute = 1'b0; rv.tone = c_SIL;
        rv.busy = 1'b0; rv.id = 2'd0; rv.step = 3'd0; rv.done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", rv);
        rst = 1'b0;

        // Quiet after reset
        idle(20, 3'd0, 0, 0, 1'b0);
        run("idle");

        // Full paddle effect, then done pulse
        notes(3'b001, 1'b0, 0, 0, 4, 1'b0, -1);
        idle(3, 3'd0, 0, 4, 1'b1);
        run("paddle");

        // Retrigger on the same edge as the effect end: restart, no done
        notes(3'b001, 1'b0, 0, 0, 4, 1'b0, -1);
        notes(3'b001, 1'b0, 0, 0, 4, 1'b0, -1);
        idle(2, 3'd0, 0, 4, 1'b1);
        run("retrig_end");

        // Win preempts paddle in step 2
        notes(3'b001, 1'b0, 0, 0, 1, 1'b0, -1);
        add(3'd0, 1'b0, 1'b0, 587, 1'b1, 0, 2, 1'b0);
        add(3'd0, 1'b0, 1'b0, 587, 1'b1, 0, 2, 1'b0);
        notes(3'b100, 1'b0, 2, 0, 5, 1'b0, -1);
        idle(2, 3'd0, 2, 5, 1'b1);
        run("preempt");

        // Border during win is dropped
        notes(3'b100, 1'b0, 2, 0, 1, 1'b0, -1);
        notes(3'b010, 1'b0, 2, 2, 5, 1'b0, -1);
        idle(2, 3'd0, 2, 5, 1'b1);
        run("low_prio");

        // Win held high for 50 cycles plays once
        notes(3'b100, 1'b1, 2, 0, 5, 1'b0, -1);
        idle(26, 3'b100, 2, 5, 1'b1);
        idle(2, 3'd0, 2, 5, 1'b0);
        run("held");

        // Border with repeat, then drop repeat during the second note
        notes(3'b010, 1'b0, 1, 0, 1, 1'b1, -1);
        notes(3'b000, 1'b0, 1, 0, 1, 1'b1, -1);
        notes(3'b000, 1'b0, 1, 0, 1, 1'b1, -1);
        notes(3'b000, 1'b0, 1, 0, 0, 1'b1, -1);
        notes(3'b000, 1'b0, 1, 1, 1, 1'b0, -1);
        idle(2, 3'd0, 1, 1, 1'b1);
        run("repeat");

        // Mute mid-paddle: silence next edge, steps keep advancing
        notes(3'b001, 1'b0, 0, 0, 4, 1'b0, 6);
        idle(2, 3'd0, 0, 4, 1'b1);
        run("mute");

        // Async reset in the middle of a border effect
        notes(3'b010, 1'b0, 1, 0, 0, 1'b1, -1);
        add(3'd0, 1'b1, 1'b0, 659, 1'b1, 1, 1, 1'b0);
        run("pre_rst");
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", rv);
        @(posedge clk);
        #1;
        check("rst_hold", rv);
        rst = 1'b0;
        idle(3, 3'd0, 0, 0, 1'b0);
        run("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
Event-driven sound-effect player for Pong. Game logic pulses a trigger for paddle hit, border hit or win. The block steps through that effect's note list at a parametrised beat rate and drives a registered tone frequency, in Hz, to the existing buzzer/PWM tone generator. It replaces the static beat-to-tone lookup with internal sequencing, priority preemption, retrigger, repeat and mute.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BEAT_HZ, 8, note steps per second; DIV = CLK_HZ/BEAT_HZ (integer), DIV >= 2 required
TONE_W, 32, tone output width; must be >= 15
SILENCE, 20000, tone value meaning "no sound" (above audible range)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
trig  in  3  effect requests: [0] paddle, [1] border, [2] win; higher index = higher priority
repeat_en  in  1  when high at end of an effect, restart it from step 0 instead of stopping
mute  in  1  forces tone to SILENCE; sequencing continues
tone  out  TONE_W  current note frequency in Hz (registered)
busy  out  1  high while an effect is playing
sfx_id  out  2  id of the playing effect (0/1/2); holds last id when idle
step  out  3  current note index within the effect
done  out  1  one-cycle pulse when an effect ends naturally

Behaviour:
- Reset (async, any time, including mid-effect): state IDLE, tone=SILENCE, busy=0, sfx_id=0, step=0, done=0, beat counter=0, trig history=0.
- Edge detect: trig_q <= trig each cycle; event = trig & ~trig_q. A held level plays once.
- Selected event = highest set index of event.
- Note tables (Hz):
  - paddle (len 5): 466,466,587,587,587
  - border (len 2): 987,659
  - win (len 6): 466,523,587,466,587,622
- States:
  - IDLE: tone=SILENCE. On any event, at that same clock edge: go to PLAY, sfx_id=sel, step=0, counter=0, busy=1, tone=table[sel][0]. Latency: tone valid after the first edge at which trig is sampled high.
  - PLAY: counter increments each cycle. At counter==DIV-1, counter wraps to 0 and the step ends. Each step is exactly DIV cycles.
    - If step < len-1: step+1 and tone updates at that edge.
    - If step==len-1 and repeat_en=1: step=0, tone=table[id][0], no done pulse.
    - If step==len-1 and repeat_en=0: go to IDLE, tone=SILENCE, busy=0, done=1 for one cycle; sfx_id and step hold.
- Preemption in PLAY:
  - sel > sfx_id: restart with the new effect (step 0, counter 0).
  - sel == sfx_id: retrigger, restarting the same effect from step 0.
  - sel < sfx_id: event is ignored and dropped, not queued.
- Simultaneous events: an event on the same edge as an end-of-effect or step wrap takes precedence. It restarts per the rules above, and no done pulse is issued.
- mute: tone output = SILENCE whenever mute=1 (registered, so it takes effect one edge later). It does not affect busy, step, done or the counter.
- Counter width: $clog2(DIV). Tone constants are zero-extended to TONE_W.

Decomposition:
- Package sfx_pkg holds:
  - note frequency constants (NOTE_BB, NOTE_C, NOTE_D, NOTE_EB, NOTE_E, NOTE_B, SILENCE default)
  - SFX id constants (SFX_PADDLE=0, SFX_BORDER=1, SFX_WIN=2)
  - per-effect length constants
  - a constant function sfx_note(id, step) returning the frequency
- One sub-module, beat_timer, contains:
  - parameter DIV
  - inputs clk, rst, clear
  - output tick, a one-cycle pulse at count DIV-1

Test Plan:
(Sim parameters CLK_HZ=16, BEAT_HZ=4, so DIV=4.)
1. Reset released, no trig for 20 cycles -> tone=20000, busy=0, done never pulses.
2. Pulse trig[0] once -> tone sequence 466,466,587,587,587, each held exactly 4 cycles. Then tone=20000, busy falls, done high for exactly 1 cycle.
3. Paddle playing at step 2, pulse trig[2] -> next edge tone=466, sfx_id=2, step=0. Win plays all 6 notes (…622), then done.
4. Win playing, pulse trig[1] -> ignored; tone continues the win sequence unchanged. Hold trig[2] high for 50 cycles from idle -> exactly one win play.
5. repeat_en=1 with border -> tone alternates 987,659 indefinitely with no done. Drop repeat_en during note 2 -> stops after that note with done=1.
6. Assert mute mid-paddle -> tone=20000 one edge later while step keeps advancing. Assert rst mid-effect -> all outputs return to reset values immediately, asynchronously.
